ddr3_fastpath_fifo: RTL
=======================

Name: ddr3_fastpath_fifo

Overview:
- Read-request and read-data buffer placed between a high-priority AXI4 read master (CPU cache-line fetch) and the bypass fast-read port of the DDR3 controller.
- Forwards one read request at a time to the fast path, but only once free FIFO space covers the whole burst. It then holds read-ready high until the last beat, so the fast path never sees a wait-state.
- Buffers the returned beats and replays them to the master with full AXI4 back-pressure.

Parameters:
- WIDTH, 32, data width in bits.
- REQID, 4, AXI ID width.
- ADDRS, 23, address width (word/burst aligned, as used by the controller).
- DEPTH, 16, FIFO depth in beats; power of two, at least 4.

Ports:
- clock  in  1  controller clock domain.
- reset_n  in  1  reset, asynchronous assert, active-low.
- s_arvalid_i / s_arready_o  in/out  1  master AR handshake.
- s_araddr_i  in  ADDRS  read address.
- s_arid_i  in  REQID  read ID.
- s_arlen_i  in  8  burst length minus 1.
- s_arburst_i  in  2  burst type.
- s_rvalid_o / s_rready_i  out/in  1  master R handshake.
- s_rdata_o  out  WIDTH  read data.
- s_rresp_o  out  2  read response.
- s_rid_o  out  REQID  read ID.
- s_rlast_o  out  1  last beat of burst.
- m_arvalid_o / m_arready_i  out/in  1  fast-path AR handshake.
- m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o  out  ADDRS/REQID/8/2  registered request fields.
- m_rvalid_i / m_rready_o  in/out  1  fast-path R handshake.
- m_rdata_i  in  WIDTH  read data.
- m_rresp_i  in  2  read response.
- m_rid_i  in  REQID  read ID.
- m_rlast_i  in  1  last beat of burst.
- err_ovf_o  out  1  sticky: beat arrived with FIFO full.
- err_last_o  out  1  sticky: m_rlast_i not on expected beat.

Behaviour:
- Reset:
  - reset_n low clears state to IDLE and all pointers and counts.
  - All valid/ready outputs and both error flags go to 0; request registers go to 0.
  - Takes effect immediately, including mid-burst. A burst in flight is abandoned and FIFO contents are discarded.
- Occupancy tracking:
  - count is clog2(DEPTH)+1 bits.
  - free = DEPTH - count.
  - need = s_arlen_i + 1, computed 9 bits wide.
- IDLE:
  - s_arready_o = 1 iff need <= free, or need > DEPTH (oversize).
  - On handshake, capture addr/id/len/burst and the beat counter beats = arlen.
  - Normal request goes to REQ; oversize request goes to ERR.
- REQ:
  - m_arvalid_o = 1 and m_rready_o = 1; both are asserted together in the cycle after the s_ AR handshake.
  - On m_arready_i, go to DATA with m_arvalid_o = 0 the next cycle.
  - m_arid_o/m_araddr_o stay stable from REQ entry until DATA exit, because the fast path echoes arid combinationally.
- DATA:
  - m_rready_o = 1 continuously.
  - Each m_rvalid_i pushes {rid, rresp, rlast, rdata} and decrements beats.
  - If m_rlast_i is seen with beats != 0, or beats == 0 without m_rlast_i, set err_last_o; the stored rlast is forced to (beats == 0).
  - After the beats == 0 push, return to IDLE; m_rready_o drops the next cycle.
- ERR:
  - Pushes arlen+1 locally generated beats, one per cycle while count < DEPTH: rdata = 0, rresp = SLVERR (2'b10), rid = captured ID, rlast on the final beat.
  - No downstream request is issued; returns to IDLE after the final push.
- FIFO:
  - Output is registered: a beat pushed at cycle N is visible on s_rvalid_o at N+1 at the earliest.
  - Pop on s_rvalid_o & s_rready_i.
  - Simultaneous push and pop leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - s_* outputs hold stable while s_rvalid_o = 1 and s_rready_i = 0.
- Overflow: a push while count == DEPTH sets err_ovf_o and the beat is dropped. This cannot occur given IDLE admission; it is checked by assertion.
- Error flags clear only on reset.
- Pipelining: the next request may be admitted in IDLE while earlier beats still drain. Admission uses the current free count, so drain and admit may overlap.
- A new s_ request is never accepted outside IDLE.

Test Plan:
- Reset, then s_arlen=3 at araddr 0x000100, id 5; fast path returns 4 beats back-to-back -> m_arvalid high the cycle after the handshake; m_rready high through rlast; master sees 4 beats, id 5, last on beat 4, OKAY.
- Master holds s_rready_i=0 during a 4-beat burst -> FIFO count reaches 4, no loss. Then s_rready=1 -> 4 beats in order on consecutive cycles.
- DEPTH=16, 12 beats undrained, s_arlen=7 -> s_arready_o=0. Pop 4 beats -> s_arready_o=1 in the cycle free reaches 8.
- s_arlen=31 with DEPTH=16 -> no m_arvalid_o; master receives 32 beats with rresp=2'b10, rdata=0, rlast on beat 32 (after stalls while full).
- Fast path asserts m_rlast_i on beat 3 of a 4-beat burst -> err_last_o=1 and stays 1; master sees 4 beats with rlast only on beat 4.
- reset_n pulsed low during DATA with 2 beats buffered -> s_rvalid_o, m_rready_o and m_arvalid_o drop to 0 asynchronously; after release: state IDLE, count 0, s_arready_o=1.

Source files
------------

// File: rtl/ddr3_fastpath_fifo.sv
// ddr3_fastpath_fifo: admits one AXI read burst at a time to the DDR3 fast path once the
// whole burst fits in the beat FIFO, then replays buffered beats to the master.
module ddr3_fastpath_fifo #(
    parameter int WIDTH = 32,
    parameter int REQID = 4,
    parameter int ADDRS = 23,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             s_arvalid_i,
    output logic             s_arready_o,
    input  logic [ADDRS-1:0] s_araddr_i,
    input  logic [REQID-1:0] s_arid_i,
    input  logic [7:0]       s_arlen_i,
    input  logic [1:0]       s_arburst_i,
    output logic             s_rvalid_o,
    input  logic             s_rready_i,
    output logic [WIDTH-1:0] s_rdata_o,
    output logic [1:0]       s_rresp_o,
    output logic [REQID-1:0] s_rid_o,
    output logic             s_rlast_o,
    output logic             m_arvalid_o,
    input  logic             m_arready_i,
    output logic [ADDRS-1:0] m_araddr_o,
    output logic [REQID-1:0] m_arid_o,
    output logic [7:0]       m_arlen_o,
    output logic [1:0]       m_arburst_o,
    input  logic             m_rvalid_i,
    output logic             m_rready_o,
    input  logic [WIDTH-1:0] m_rdata_i,
    input  logic [1:0]       m_rresp_i,
    input  logic [REQID-1:0] m_rid_i,
    input  logic             m_rlast_i,
    output logic             err_ovf_o,
    output logic             err_last_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = REQID + 3 + WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, DATA, ERR} state_t;

    state_t          state;
    logic [7:0]      beats;
    logic [CW-1:0]   mem_cnt, count, free;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   mem [DEPTH];
    logic [PW-1:0]   out_word, push_word;
    logic [8:0]      need;
    logic            beat, push, room, do_push, pop, load, mem_rd, bypass;

    assign {s_rid_o, s_rresp_o, s_rlast_o, s_rdata_o} = out_word;

    always_comb begin
        count = mem_cnt + CW'(s_rvalid_o);
        free = CW'(DEPTH) - count;
        need = 9'(s_arlen_i) + 9'd1;
        room = count != CW'(DEPTH);
        s_arready_o = reset_n && state == IDLE && (int'(need) <= int'(free) || int'(need) > DEPTH);
        beat = m_rready_o & m_rvalid_i;
        push = beat | (state == ERR & room);
        push_word = beat ? {m_rid_i, m_rresp_i, beats == 8'd0, m_rdata_i}
                         : {m_arid_o, 2'b10, beats == 8'd0, {WIDTH{1'b0}}};
        do_push = push & room;
        pop = s_rvalid_o & s_rready_i;
        load = !s_rvalid_o | pop;
        mem_rd = load & (mem_cnt != '0);
        // an empty FIFO feeds the output register directly so a beat appears one cycle later
        bypass = load & (mem_cnt == '0) & do_push;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            beats <= '0;
            m_araddr_o <= '0;
            m_arid_o <= '0;
            m_arlen_o <= '0;
            m_arburst_o <= '0;
            m_arvalid_o <= 1'b0;
            m_rready_o <= 1'b0;
            err_last_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s_arvalid_i && s_arready_o) begin
                    m_araddr_o <= s_araddr_i;
                    m_arid_o <= s_arid_i;
                    m_arlen_o <= s_arlen_i;
                    m_arburst_o <= s_arburst_i;
                    beats <= s_arlen_i;
                    if (int'(need) > DEPTH) begin
                        state <= ERR;
                    end else begin
                        state <= REQ;
                        m_arvalid_o <= 1'b1;
                        m_rready_o <= 1'b1;
                    end
                end
                REQ, DATA: begin
                    if (state == REQ && m_arready_i) begin
                        state <= DATA;
                        m_arvalid_o <= 1'b0;
                    end
                    if (beat) begin
                        if (m_rlast_i != (beats == 8'd0)) err_last_o <= 1'b1;
                        beats <= beats - 8'd1;
                        if (beats == 8'd0) begin
                            state <= IDLE;
                            m_arvalid_o <= 1'b0;
                            m_rready_o <= 1'b0;
                        end
                    end
                end
                ERR: if (do_push) begin
                    beats <= beats - 8'd1;
                    if (beats == 8'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_cnt <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            s_rvalid_o <= 1'b0;
            out_word <= '0;
            err_ovf_o <= 1'b0;
        end else begin
            if (push && !room) err_ovf_o <= 1'b1;
            if (do_push && !bypass) wr_ptr <= wr_ptr + 1'b1;
            if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
            mem_cnt <= mem_cnt + CW'(do_push & !bypass) - CW'(mem_rd);
            if (load) begin
                s_rvalid_o <= mem_rd | bypass;
                if (mem_rd) out_word <= mem[rd_ptr];
                else if (bypass) out_word <= push_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !bypass) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clock) begin
        if (reset_n) assert (!push || room);
    end
endmodule
